// File: rtl/port_serial_tx.sv
// port_serial_tx
//   Serial transmit peripheral sitting on one MMIO port pair. The even port
//   word carries a data byte and the odd port word carries a command. A command
//   is recognised only when bit 15 of the command word toggles. Accepted bytes
//   are queued in a small FIFO and shifted out as 8N1 frames on tx.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous reset, active high
//   port_data_word  [7:0] byte to push
//   port_cmd_word   [15] sequence toggle, [1:0] op (00 nop, 01 push, 10 flush, 11 ignored)
//   status_word     [15] done toggle, [14] overflow, [13] busy, [12] full,
//                   [11:5] zero, [4:0] FIFO count; registered, one cycle behind
//   tx              serial line, idle high
//   tx_active       high while a frame is on the line
//
// FSM states
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte in the FIFO
//   S_START | start bit (low) for CLK_DIV cycles
//   S_DATA  | eight data bits, LSB first, CLK_DIV cycles each
//   S_STOP  | stop bit (high); back-to-back pop if more bytes are queued
module port_serial_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] port_data_word,
    input  logic [15:0] port_cmd_word,
    output logic [15:0] status_word,
    output logic        tx,
    output logic        tx_active
);

    localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);
    localparam logic [4:0]  CNT_FULL = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [15:0]        cmd_q;
    logic [7:0]         data_q;
    logic               last_seq;
    logic               cmd_stb;
    logic               do_push;
    logic               do_flush;
    logic               do_write;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [4:0]         count_q;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_pop;
    logic               pop_ok;
    logic               ovf_q;

    logic [15:0]        bit_timer;
    logic               bit_last;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_q;
    logic               done_q;
    logic               frame_done;
    logic               busy;

    logic               unused_bits;
    assign unused_bits = ^{port_data_word[15:8], cmd_q[14:2]};

    // Port words are registered without reset so that the reset edge captures
    // the current command word alongside last_seq.
    always_ff @(posedge clk) begin
        cmd_q  <= port_cmd_word;
        data_q <= port_data_word[7:0];
    end

    // Written as an if so that an unknown bit 15 falls to the no-strobe path.
    always_comb begin
        cmd_stb = 1'b0;
        if (cmd_q[15] != last_seq) begin
            cmd_stb = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_seq <= port_cmd_word[15];
        end else if (cmd_stb) begin
            last_seq <= cmd_q[15];
        end
    end

    assign do_push    = cmd_stb && (cmd_q[1:0] == 2'b01);
    assign do_flush   = cmd_stb && (cmd_q[1:0] == 2'b10);
    assign fifo_empty = (count_q == 5'd0);
    assign fifo_full  = (count_q == CNT_FULL);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_write   = do_push && (!fifo_full || fifo_pop);
    assign pop_ok     = !fifo_empty && !do_flush;

    always_ff @(posedge clk) begin
        if (do_write) begin
            fifo_mem[wr_ptr] <= data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= 5'd0;
            ovf_q   <= 1'b0;
        end else if (do_flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= 5'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_write) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_q + 5'(do_write) - 5'(fifo_pop);
        end
    end

    assign bit_last = (bit_timer == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_ok) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_last && (bit_idx == 3'd7)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_last) begin
                    state_d = pop_ok ? S_START : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx         = 1'b1;
        tx_active  = 1'b0;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                fifo_pop = pop_ok;
            end
            S_START: begin
                tx        = 1'b0;
                tx_active = 1'b1;
            end
            S_DATA: begin
                tx        = shift_q[bit_idx];
                tx_active = 1'b1;
            end
            S_STOP: begin
                tx_active  = 1'b1;
                frame_done = bit_last;
                fifo_pop   = bit_last && pop_ok;
            end
            default: ;
        endcase
    end

    // Timer restarts on every state entry so frame timing never accumulates drift.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_timer <= 16'd0;
            bit_idx   <= 3'd0;
            shift_q   <= 8'd0;
            done_q    <= 1'b0;
        end else begin
            if ((state_d != state_q) || (state_q == S_IDLE) || bit_last) begin
                bit_timer <= 16'd0;
            end else begin
                bit_timer <= bit_timer + 16'd1;
            end
            if (state_q != S_DATA) begin
                bit_idx <= 3'd0;
            end else if (bit_last) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (fifo_pop) begin
                shift_q <= fifo_mem[rd_ptr];
            end
            if (frame_done) begin
                done_q <= ~done_q;
            end
        end
    end

    assign busy = tx_active | !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_word <= 16'h0000;
        end else begin
            status_word <= {done_q, ovf_q, busy, fifo_full, 7'b0, count_q};
        end
    end

endmodule
